// File: rtl/fp_stft_pkg.sv
// ==== fp_stft_pkg : shared constants and FSM encoding for the FP STFT front end (rev 1.0) ====
`default_nettype none

package fp_stft_pkg;

  localparam logic [31:0] FP_ONE    = 32'h3F800000;
  localparam logic [31:0] FP_ZERO   = 32'h00000000;
  localparam logic        WIN_BOX   = 1'b0;
  localparam logic        WIN_TABLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/fp_window_seq_if.sv
// ==== fp_window_seq_if : control, table-write and coefficient stream bundle (rev 1.0) ====
`default_nettype none

interface fp_window_seq_if #(
  parameter int W  = 4,
  parameter int AW = $clog2(W)
);

  logic          start;
  logic          mode;
  logic          cont;
  logic          stop;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          ready_in;
  logic [31:0]   re_w;
  logic [31:0]   im_w;
  logic [AW-1:0] index_out;
  logic          valid_out;
  logic          last_out;
  logic          busy;

  modport master (
    output start, mode, cont, stop, wr_en, wr_addr, wr_data, ready_in,
    input  re_w, im_w, index_out, valid_out, last_out, busy
  );

  modport slave (
    input  start, mode, cont, stop, wr_en, wr_addr, wr_data, ready_in,
    output re_w, im_w, index_out, valid_out, last_out, busy
  );

endinterface

`default_nettype wire

// File: rtl/fp_window_rom.sv
// ==== fp_window_rom : W x 32 window table, single write port, synchronous read (rev 1.0) ====
`default_nettype none

module fp_window_rom #(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [$clog2(W)-1:0] wr_addr,
  input  logic [31:0]          wr_data,
  input  logic [$clog2(W)-1:0] rd_addr,
  output logic [31:0]          rd_data
);

  logic [31:0] mem_q [W];

  // No reset on the array or read port so the table maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data <= mem_q[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/fp_window_seq.sv
// ==== fp_window_seq : window-coefficient sequencer, table read + output stage under valid/ready (rev 1.0) ====
`default_nettype none

module fp_window_seq
  import fp_stft_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst,
  fp_window_seq_if.slave  bus
);

  localparam int            AW       = $clog2(W);
  localparam logic [AW-1:0] LAST_IDX = AW'(W - 1);

  seq_state_e    state_q;
  logic          busy_q;
  logic          mode_q;
  logic          cont_q;
  logic          stop_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] idx_d;
  logic          s1_valid_q;
  logic [AW-1:0] s1_idx_q;
  logic [31:0]   s1_data;
  logic          valid_q;
  logic [31:0]   re_q;
  logic [AW-1:0] out_idx_q;
  logic          last_q;
  logic [31:0]   rom_rd;
  logic          out_ready;
  logic          issue;
  logic          wr_ok;
  logic [AW-1:0] rd_addr;

  assign out_ready = !valid_q || bus.ready_in;
  assign issue     = (state_q == ST_RUN) && out_ready;
  assign idx_d     = idx_q + 1'b1;
  assign wr_ok     = bus.wr_en && !busy_q;
  // A stalled prefetch slot re-reads its own address so the RAM output keeps matching it.
  assign rd_addr   = out_ready ? idx_q : s1_idx_q;
  assign s1_data   = (mode_q == WIN_TABLE) ? rom_rd : FP_ONE;

  fp_window_rom #(.W(W)) u_rom (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (rd_addr),
    .rd_data (rom_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      mode_q     <= WIN_BOX;
      cont_q     <= 1'b0;
      stop_q     <= 1'b0;
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      valid_q    <= 1'b0;
      re_q       <= FP_ZERO;
      out_idx_q  <= '0;
      last_q     <= 1'b0;
    end else begin
      if (out_ready) begin
        s1_valid_q <= issue;
        s1_idx_q   <= idx_q;
        valid_q    <= s1_valid_q;
        re_q       <= s1_valid_q ? s1_data : FP_ZERO;
        out_idx_q  <= s1_valid_q ? s1_idx_q : '0;
        last_q     <= s1_valid_q && (s1_idx_q == LAST_IDX);
      end

      case (state_q)
        ST_IDLE: begin
          stop_q <= 1'b0;
          if (bus.start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            mode_q  <= bus.mode;
            cont_q  <= bus.cont;
            idx_q   <= '0;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            stop_q <= 1'b1;
          end
          if (issue) begin
            idx_q <= idx_d;
            // A stop seen on the wrap edge itself still ends the run after this frame.
            if ((idx_q == LAST_IDX) && !(cont_q && !stop_q && !bus.stop)) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (valid_q && bus.ready_in && last_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.re_w      = re_q;
  assign bus.im_w      = FP_ZERO;
  assign bus.index_out = out_idx_q;
  assign bus.valid_out = valid_q;
  assign bus.last_out  = last_q;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_window_seq.sv
// ==== tb_fp_window_seq : scoreboard bench for fp_window_seq, model holds the table and expected beats (rev 1.0) ====
`default_nettype none

module tb_fp_window_seq;

  localparam int W  = 4;
  localparam int AW = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_window_seq_if #(.W(W)) bus ();

  fp_window_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [31:0]   re;
    logic          last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] tbl_m [W];
  int          n_tests    = 0;
  int          n_fail     = 0;
  int          rdy_mode   = 0;
  int          rdy_ph     = 0;
  int          beats_seen = 0;
  logic        prev_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Expected frame: index order 0..W-1, box gives 1.0, table mode gives the model table.
  task automatic push_frame(input logic m);
    beat_t b;
    for (int i = 0; i < W; i++) begin
      b.idx  = AW'(i);
      b.re   = m ? tbl_m[i] : 32'h3F800000;
      b.last = (i == W - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.ready_in = 1'b1;
      1: bus.ready_in = ($urandom_range(0, 2) != 0);
      default: begin
        bus.ready_in = (rdy_ph == 0);
        rdy_ph = (rdy_ph + 1) % 3;
      end
    endcase
  end

  // Every valid cycle must present the head of the expected stream; an accepted one pops it.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("valid_held", 32'(bus.valid_out), 32'd1);
      if (bus.valid_out) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got idx %0d re %h, required no beat", bus.index_out, bus.re_w);
        end else begin
          chk("beat_idx", 32'(bus.index_out), 32'(exp_q[0].idx));
          chk("beat_re", bus.re_w, exp_q[0].re);
          chk("beat_last", 32'(bus.last_out), 32'(exp_q[0].last));
          chk("beat_im", bus.im_w, 32'h0);
          if (bus.ready_in) begin
            exp_q.delete(0);
            beats_seen++;
          end
        end
      end
      prev_stall = bus.valid_out && !bus.ready_in;
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input bit upd);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    if (upd) tbl_m[a] = d;
    tick;
    bus.wr_en = 1'b0;
  endtask

  // Returns at the first negedge where the first beat must be visible (start edge + 2).
  task automatic do_start(input logic m, input logic c, input int nfr, input string tag);
    for (int f = 0; f < nfr; f++) push_frame(m);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.cont  = c;
    tick;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    bus.mode  = 1'($urandom);
    bus.cont  = 1'($urandom);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk({tag, "_lat_early"}, 32'(bus.valid_out), 32'd0);
    @(negedge clk);
    chk({tag, "_lat_first"}, 32'(bus.valid_out), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((bus.busy || bus.valid_out) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, 32'(k >= 400), 32'd0);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    tick;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int b0;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.cont     = 1'b0;
    bus.stop     = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.ready_in = 1'b1;

    #12;
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_re", bus.re_w, 32'h0);
    chk("rst_idx", 32'(bus.index_out), 32'd0);
    chk("rst_last", 32'(bus.last_out), 32'd0);
    rst = 1'b0;
    tick;

    // Box frame at full throughput.
    rdy_mode = 0;
    tick;
    do_start(1'b0, 1'b0, 1, "t1");
    chk("t1_first_re", bus.re_w, 32'h3F800000);
    chk("t1_first_idx", 32'(bus.index_out), 32'd0);
    repeat (3) @(negedge clk);
    chk("t1_last_flag", 32'(bus.last_out), 32'd1);
    chk("t1_last_idx", 32'(bus.index_out), 32'd3);
    chk("t1_busy_at_last", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("t1_busy_after", 32'(bus.busy), 32'd0);
    chk("t1_valid_after", 32'(bus.valid_out), 32'd0);
    tick;

    // Table load then table frame.
    wr(2'd0, 32'h00000000, 1'b1);
    wr(2'd1, 32'h3F000000, 1'b1);
    wr(2'd2, 32'h3F800000, 1'b1);
    wr(2'd3, 32'h3F000000, 1'b1);
    do_start(1'b1, 1'b0, 1, "t2");
    chk("t2_re0", bus.re_w, 32'h00000000);
    @(negedge clk);
    chk("t2_re1", bus.re_w, 32'h3F000000);
    wait_idle("t2");

    // Backpressure 1,0,0 with an ignored start while busy.
    rdy_mode = 2;
    b0 = beats_seen;
    do_start(1'b1, 1'b0, 1, "t3");
    tick;
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    tick;
    bus.start = 1'b0;
    wait_idle("t3");
    chk("t3_beats", 32'(beats_seen - b0), 32'd4);

    // Continuous run, stop raised while frame 3 begins.
    rdy_mode = 0;
    tick;
    do_start(1'b1, 1'b1, 3, "t4");
    n = 1;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      bus.stop = 1'b0;
      if (!bus.valid_out) break;
      n++;
      if (n == 9) bus.stop = 1'b1;
    end
    bus.stop = 1'b0;
    chk("t4_gapfree_beats", 32'(n), 32'd12);
    chk("t4_busy_end", 32'(bus.busy), 32'd0);
    wait_idle("t4");

    // Writes while busy are dropped; IDLE writes and write-with-start land.
    do_start(1'b1, 1'b0, 1, "t5a");
    tick;
    wr(2'd1, 32'h40000000, 1'b0);
    wait_idle("t5a");
    do_start(1'b1, 1'b0, 1, "t5b");
    @(negedge clk);
    chk("t5b_old_re1", bus.re_w, 32'h3F000000);
    wait_idle("t5b");
    wr(2'd1, 32'h40000000, 1'b1);
    do_start(1'b1, 1'b0, 1, "t5c");
    @(negedge clk);
    chk("t5c_new_re1", bus.re_w, 32'h40000000);
    wait_idle("t5c");
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd2;
    bus.wr_data = 32'h3E800000;
    tbl_m[2]    = 32'h3E800000;
    do_start(1'b1, 1'b0, 1, "t5d");
    repeat (2) @(negedge clk);
    chk("t5d_same_cycle_re2", bus.re_w, 32'h3E800000);
    wait_idle("t5d");

    // Asynchronous reset mid-frame.
    do_start(1'b0, 1'b0, 1, "t6");
    k = 0;
    while (!(bus.valid_out && bus.index_out == 2'd2) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reach_idx2", 32'(k >= 50), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.valid_out), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    tick;
    chk("t6_idle_idx", 32'(bus.index_out), 32'd0);
    do_start(1'b1, 1'b0, 1, "t6b");
    chk("t6b_first_idx", 32'(bus.index_out), 32'd0);
    wait_idle("t6b");

    // Randomized frames with random table contents and random backpressure.
    rdy_mode = 1;
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 2; j++) begin
        wr(AW'($urandom_range(0, W - 1)), $urandom, 1'b1);
      end
      do_start(1'($urandom), 1'b0, 1, "rnd");
      wait_idle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
